uart_rx_frame_check: RTL and testbench

UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_err_counter.sv | 22 ++
 rtl/uart_rx_frame_check.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame checker.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_err_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module uart_err_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive framer: assembles a frame from pre-sampled bit strobes and
// reports parity, stop and break conditions with saturating error counts.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  two_stop,
  input  logic                  cnt_clr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  break_det,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH);

  rx_state_t             state, state_n;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bit_cnt;
  logic                  par_en_l, par_typ_l, two_stop_l;
  logic                  par_x;      // running XOR of data and parity bits
  logic                  nz;         // any 1 seen in data/parity/first stop
  logic                  stop_acc;   // first stop bit was 0

  logic                  start_seen;
  logic                  frame_end;
  logic                  par_err_n, stop_err_n, break_n, ok_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    start_seen = 1'b0;
    frame_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bit_valid && !sampled_bit) begin
          state_n    = ST_DATA;
          start_seen = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_valid && (bit_cnt == BCW'(DATA_WIDTH - 1))) begin
          state_n = par_en_l ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        if (bit_valid) begin
          state_n = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bit_valid) begin
          if (two_stop_l) begin
            state_n = ST_STOP2;
          end else begin
            state_n   = ST_IDLE;
            frame_end = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (bit_valid) begin
          state_n   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Final flags fold in the stop bit currently on sampled_bit; stop_acc is
  // cleared at start, so it is only non-zero when ending in STOP2.
  always_comb begin
    par_err_n  = par_en_l && (par_x != par_typ_l);
    stop_err_n = stop_acc | ~sampled_bit;
    break_n    = ~(nz | sampled_bit);
    ok_n       = ~(par_err_n | stop_err_n | break_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= PAR_EVEN;
      two_stop_l <= 1'b0;
      par_x      <= 1'b0;
      nz         <= 1'b0;
      stop_acc   <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      data_valid <= frame_end & ok_n;

      if (start_seen) begin
        par_en_l   <= par_en;
        par_typ_l  <= par_typ;
        two_stop_l <= two_stop;
        bit_cnt    <= '0;
        par_x      <= 1'b0;
        nz         <= 1'b0;
        stop_acc   <= 1'b0;
      end

      if (bit_valid) begin
        case (state)
          ST_DATA: begin
            shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BCW'(1);
            par_x   <= par_x ^ sampled_bit;
            nz      <= nz | sampled_bit;
          end
          ST_PARITY: begin
            par_x <= par_x ^ sampled_bit;
            nz    <= nz | sampled_bit;
          end
          ST_STOP1: begin
            stop_acc <= ~sampled_bit;
            nz       <= nz | sampled_bit;
          end
          default: ;
        endcase
      end

      if (frame_end) begin
        par_err   <= par_err_n;
        stop_err  <= stop_err_n;
        break_det <= break_n;
        if (ok_n) begin
          data <= shreg;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

  uart_err_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_par_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (frame_end & par_err_n),
    .count (par_err_cnt)
  );

  uart_err_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (frame_end & stop_err_n),
    .count (stop_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check: frame table plus corner sequences.
module tb_uart_rx_frame_check;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_valid = 1'b0;
  logic          sampled_bit = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          two_stop = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          busy;
  logic [DW-1:0] data;
  logic          frame_done, data_valid, par_err, stop_err, break_det;
  logic [CW-1:0] par_err_cnt, stop_err_cnt;

  uart_rx_frame_check #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_valid    (bit_valid),
    .sampled_bit  (sampled_bit),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .two_stop     (two_stop),
    .cnt_clr      (cnt_clr),
    .busy         (busy),
    .data         (data),
    .frame_done   (frame_done),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stop_err     (stop_err),
    .break_det    (break_det),
    .par_err_cnt  (par_err_cnt),
    .stop_err_cnt (stop_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pe, pt, ts;
    logic [DW-1:0] d;
    logic          p, s1, s2;
    logic          e_par, e_stop, e_brk;
  } vec_t;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  logic [DW-1:0] exp_data = '0;
  logic [CW-1:0] exp_pcnt = '0;
  logic [CW-1:0] exp_scnt = '0;
  logic          exp_par = 1'b0, exp_stop = 1'b0, exp_brk = 1'b0;
  vec_t          vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  // Caller is at a negedge; the strobe is captured by the following posedge.
  task automatic strobe(input logic b, input logic clr);
    bit_valid   = 1'b1;
    sampled_bit = b;
    cnt_clr     = clr;
    @(negedge clk);
    bit_valid   = 1'b0;
    sampled_bit = 1'b1;
    cnt_clr     = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data"}, 32'(data), 32'(exp_data));
    check({tag, ".par_err"}, 32'(par_err), 32'(exp_par));
    check({tag, ".stop_err"}, 32'(stop_err), 32'(exp_stop));
    check({tag, ".break_det"}, 32'(break_det), 32'(exp_brk));
    check({tag, ".par_cnt"}, 32'(par_err_cnt), 32'(exp_pcnt));
    check({tag, ".stop_cnt"}, 32'(stop_err_cnt), 32'(exp_scnt));
  endtask

  task automatic send_frame(input vec_t v, input logic clr_last, input string tag);
    logic [11:0] bits;
    int          n;
    logic        dv;
    bits = '0;
    n    = 0;
    for (int i = 0; i < int'(DW); i++) begin bits[n] = v.d[i]; n++; end
    if (v.pe) begin bits[n] = v.p; n++; end
    bits[n] = v.s1; n++;
    if (v.ts) begin bits[n] = v.s2; n++; end

    par_en = v.pe; par_typ = v.pt; two_stop = v.ts;
    strobe(1'b0, 1'b0);
    // Config is flipped mid-frame and must have no effect.
    par_en = ~v.pe; par_typ = ~v.pt; two_stop = ~v.ts;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      strobe(bits[k], (k == n - 1) ? clr_last : 1'b0);
      if (k != n - 1) begin
        check({tag, ".busy_mid"}, 32'(busy), 32'd1);
        check({tag, ".no_early_done"}, 32'(frame_done), 32'd0);
      end
    end

    dv = ~(v.e_par | v.e_stop | v.e_brk);
    exp_par = v.e_par; exp_stop = v.e_stop; exp_brk = v.e_brk;
    if (dv) exp_data = v.d;
    if (clr_last) begin
      exp_pcnt = '0; exp_scnt = '0;
    end else begin
      if (v.e_par)  exp_pcnt = sat_inc(exp_pcnt);
      if (v.e_stop) exp_scnt = sat_inc(exp_scnt);
    end
    check({tag, ".frame_done"}, 32'(frame_done), 32'd1);
    check({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check_outputs(tag);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
    check({tag, ".dv_pulse"}, 32'(data_valid), 32'd0);
    check_outputs({tag, ".hold"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pe    pt    ts    d      p     s1    s2    par   stop  brk
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // 8N1 ok
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // 8E1 bad parity
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // 8N2 stop2=0
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}; // 8O1 break
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // 8E1 ok
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // 8O1 ok
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // 8N2 stop1=0
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // 8N1 break
    vecs[8] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // 8E2 stop2=0
    vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // 8N1 ok

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.frame_done", 32'(frame_done), 32'd0);
    check("rst.data_valid", 32'(data_valid), 32'd0);
    check_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d", i));
    end

    // Back-to-back: next start bit lands while frame_done is high.
    send_frame(vecs[2], 1'b0, "b2b_a");
    send_frame(vecs[0], 1'b0, "b2b_b");
    idle_check("b2b_b");

    // Start bit sampled high is rejected.
    strobe(1'b1, 1'b0);
    check("glitch.busy", 32'(busy), 32'd0);
    check("glitch.frame_done", 32'(frame_done), 32'd0);
    idle_check("glitch");
    check("glitch.busy2", 32'(busy), 32'd0);

    // Counter clear, saturation, and clear coincident with an error.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_pcnt = '0; exp_scnt = '0;
    check("clr.par_cnt", 32'(par_err_cnt), 32'd0);
    check("clr.stop_cnt", 32'(stop_err_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_frame('{1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b0,
                 $sformatf("sat%0d", i));
    end
    check("sat.stop_cnt_max", 32'(stop_err_cnt), 32'd3);
    send_frame('{1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1, "clr_win");
    idle_check("clr_win");

    // Reset in the middle of the data bits aborts the frame.
    par_en = 1'b0; par_typ = 1'b0; two_stop = 1'b0;
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_data = '0; exp_pcnt = '0; exp_scnt = '0;
    exp_par = 1'b0; exp_stop = 1'b0; exp_brk = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle_check($sformatf("abort%0d", i));
    end
    send_frame(vecs[9], 1'b0, "recover");
    idle_check("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
